// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the sequential divider.
//   div_state_e : FSM state encoding (IDLE, RUN, DONE)
//   DZ_QUOTIENT : quotient reported on divide-by-zero (all ones); slice the
//                 low WIDTH bits for the operand width in use
// -----------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic [MAX_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_stage.sv
// -----------------------------------------------------------------------------
// div_sub_stage
// Unsigned subtractor diff = a - b built as a ripple of full-adder cells:
// a + ~b + 1. The final carry-out is 1 when no borrow occurred.
//   a      : minuend, W bits
//   b      : subtrahend, W bits
//   diff   : a - b modulo 2**W
//   borrow : 1 when b > a
// -----------------------------------------------------------------------------
module div_sub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W-1:0] b_inv;
    logic [W:0]   carry;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign diff[i]    = a[i] ^ b_inv[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
    end

    assign borrow = ~carry[W];

endmodule

// File: rtl/seq_div4bit.sv
// -----------------------------------------------------------------------------
// seq_div4bit
// Sequential restoring divider, one quotient bit per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request pulse, only looked at while idle
//   dividend     : unsigned numerator, captured when start is accepted
//   divisor      : unsigned denominator, captured when start is accepted
//   busy         : high in RUN and DONE
//   done         : one-cycle pulse, results valid from this cycle onwards
//   quotient     : registered quotient (all ones on divide-by-zero)
//   remainder    : registered remainder (dividend on divide-by-zero)
//   div_by_zero  : registered flag, set with done when divisor was 0
//   state_dbg    : current FSM state, for observation only
//
// Handshake: start is accepted on a rising edge where busy=0 and start=1;
// operands are sampled on that same edge. Starts while busy=1 are dropped.
// done rises for exactly one cycle WIDTH+1 edges later (1 edge for divisor 0),
// and busy is already 0 in that cycle, so the next start may be presented
// alongside done.
// -----------------------------------------------------------------------------
module seq_div4bit
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e     state;
    logic [WIDTH:0] r_reg;     // partial remainder
    logic [WIDTH-1:0] q_reg;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_reg;   // latched divisor
    logic [CW-1:0]  cnt;       // remaining RUN steps minus one
    logic           dz_reg;    // latched divisor==0

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;
    logic           borrow;

    // Between steps R < D, so the top bit of R is always 0 and only the low
    // WIDTH bits feed the next shift.
    logic unused_r_msb;
    assign unused_r_msb = r_reg[WIDTH];

    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    div_sub_stage #(
        .W (WIDTH + 1)
    ) u_sub (
        .a      (r_shift),
        .b      ({1'b0, d_reg}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            dz_reg      <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg  <= dividend;
                        d_reg  <= divisor;
                        r_reg  <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        dz_reg <= (divisor == '0);
                        // A zero divisor skips the iteration entirely.
                        state  <= (divisor == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Restore by simply not taking the trial when it borrows.
                    if (!borrow) begin
                        r_reg <= trial;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= r_shift;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    div_by_zero <= dz_reg;
                    if (dz_reg) begin
                        // q_reg still holds the untouched dividend here.
                        quotient  <= DZ_QUOTIENT[WIDTH-1:0];
                        remainder <= q_reg;
                    end else begin
                        quotient  <= q_reg;
                        remainder <= r_reg[WIDTH-1:0];
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div4bit.sv
module tb_seq_div4bit;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [3:0] dividend = 4'd0;
    logic [3:0] divisor  = 4'd0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic [1:0] state_dbg;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    // Expected {div_by_zero, quotient, remainder}
    logic [8:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_div4bit #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // ---------------- reference model ----------------
    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
        if (b == 4'd0) return {1'b1, 4'hF, a};
        return {1'b0, 4'(a / b), 4'(a % b)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge while the DUT is idle; returns #1 after the accept edge.
    task automatic drive_start(input logic [3:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start   = 1'b0;
    endtask

    // Waits (bounded) for done, checks latency in edges after the accept edge,
    // then returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int exp_lat);
        while (!done && (cyc - acc_cyc) < 20) begin
            @(posedge clk);
            #1;
        end
        check(tag, cyc - acc_cyc, exp_lat);
        check("busy_in_done_cycle", busy, 1'b0);
        @(negedge clk);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && done) begin
            done_cnt++;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL done_unexpected observed=done expected=no_done");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", {div_by_zero, quotient, remainder}, e);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int d0;

        // Reset state
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quotient", quotient, 4'd0);
        check("rst_remainder", remainder, 4'd0);
        check("rst_dz", div_by_zero, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 13 / 3
        drive_start(4'd13, 4'd3);
        check("busy_in_run", busy, 1'b1);
        wait_done("lat_13_3", 5);
        @(posedge clk);
        #1;
        check("done_width", done, 1'b0);
        @(negedge clk);

        // Edge values
        drive_start(4'd15, 4'd1);
        wait_done("lat_15_1", 5);
        drive_start(4'd2, 4'd7);
        wait_done("lat_2_7", 5);
        drive_start(4'd15, 4'd15);
        wait_done("lat_15_15", 5);

        // Divide by zero, then hold
        drive_start(4'd9, 4'd0);
        wait_done("lat_9_0", 1);
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, 4'hF);
        check("hold_remainder", remainder, 4'd9);
        check("hold_dz", div_by_zero, 1'b1);
        check("hold_done_low", done, 1'b0);

        // Start and operand changes during RUN are ignored
        d0 = done_cnt;
        drive_start(4'd13, 4'd3);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'd5;
        divisor  = 4'd1;
        wait_done("lat_overlap", 5);
        @(posedge clk);
        #1;
        check("overlap_single_done", done_cnt - d0, 1);
        @(negedge clk);
        drive_start(4'd6, 4'd2);
        wait_done("lat_6_2", 5);

        // Reset in the second RUN cycle aborts
        drive_start(4'd13, 4'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        d0 = done_cnt;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_quotient", quotient, 4'd0);
        check("abort_remainder", remainder, 4'd0);
        check("abort_dz", div_by_zero, 1'b0);
        check("abort_state", state_dbg, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        drive_start(4'd7, 4'd2);
        wait_done("lat_7_2", 5);

        // Back-to-back sweep of every operand pair
        @(posedge clk);
        d0 = done_cnt;
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive_start(4'(a), 4'(b));
                wait_done("sweep_lat", (b == 0) ? 1 : 5);
            end
        end
        @(posedge clk);
        check("sweep_done_count", done_cnt - d0, 256);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
